// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
//   state_t   : one-hot FSM state encoding
//   OP_ADD/OP_SUB : add_sub codes driven to the adder/subtractor
//   PAIR_ADD/PAIR_SUB : {Q0,Q_1} Booth recoding pairs that need an add/sub
package booth_pkg;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_LOAD  = 6'b000010,
    S_CHECK = 6'b000100,
    S_ADD   = 6'b001000,
    S_SHIFT = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] PAIR_ADD = 2'b01;  // Q0=0, Q_1=1 : HQ + M
  localparam logic [1:0] PAIR_SUB = 2'b10;  // Q0=1, Q_1=0 : HQ - M

endpackage

// File: rtl/module_booth_sequencer_if.sv
// Control/status bundle between the Booth sequencer and its surroundings.
//   start, q_lsb            : requests and datapath feedback into the sequencer
//   load_a, load_b,
//   load_add, add_sub,
//   shift_hq_lq_q_1         : datapath strobes out of the sequencer
//   busy, done, iter        : status out of the sequencer
// master = control/datapath side, slave = sequencer.
interface module_booth_sequencer_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N + 1);

  logic         start;
  logic [1:0]   q_lsb;
  logic         load_a;
  logic         load_b;
  logic         load_add;
  logic         add_sub;
  logic         shift_hq_lq_q_1;
  logic         busy;
  logic         done;
  logic [W-1:0] iter;

  modport master (
    output start, q_lsb,
    input  load_a, load_b, load_add, add_sub, shift_hq_lq_q_1, busy, done, iter
  );

  modport slave (
    input  start, q_lsb,
    output load_a, load_b, load_add, add_sub, shift_hq_lq_q_1, busy, done, iter
  );
endinterface

// File: rtl/module_booth_itercnt.sv
// Loadable down-counter holding the number of Booth iterations remaining.
//   clk, rst : clock, asynchronous active-low reset (resets to N)
//   load     : reload value with N (has priority over dec)
//   dec      : decrement by one; saturates at zero
//   value    : current count
//   last     : value == 1, i.e. the current iteration is the final one
module module_booth_itercnt #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch can never be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(N);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= W'(N);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign last  = (cnt_q == W'(1));

endmodule

// File: rtl/module_booth_sequencer.sv
// Control sequencer for a radix-2 Booth multiplier datapath.
// On start it loads M and the multiplier, then for each of N iterations
// inspects {Q0,Q_1}, optionally adds/subtracts M into HQ, and shifts
// {HQ,LQ,Q_1} arithmetically right. A one-cycle done pulse ends the run.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : control/status bundle (slave side), see module_booth_sequencer_if
module module_booth_sequencer
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  module_booth_sequencer_if.slave  bus
);

  localparam int W = $clog2(N + 1);

  state_t       state_q, state_d;
  logic         add_sub_q, add_sub_d;
  logic         cnt_load, cnt_dec, cnt_last;
  logic [W-1:0] cnt_value;

  module_booth_itercnt #(.N(N), .W(W)) u_itercnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (cnt_value),
    .last  (cnt_last)
  );

  always_comb begin
    state_d             = state_q;
    add_sub_d           = OP_ADD;
    cnt_load            = 1'b0;
    cnt_dec             = 1'b0;
    bus.load_a          = 1'b0;
    bus.load_b          = 1'b0;
    bus.load_add        = 1'b0;
    bus.shift_hq_lq_q_1 = 1'b0;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.busy   = 1'b1;
        bus.load_a = 1'b1;
        bus.load_b = 1'b1;
        cnt_load   = 1'b1;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        bus.busy = 1'b1;
        // add_sub is latched here so it is stable for the whole ADD cycle.
        if (bus.q_lsb == PAIR_SUB) begin
          add_sub_d = OP_SUB;
          state_d   = S_ADD;
        end else if (bus.q_lsb == PAIR_ADD) begin
          add_sub_d = OP_ADD;
          state_d   = S_ADD;
        end else begin
          state_d   = S_SHIFT;
        end
      end
      S_ADD: begin
        bus.busy     = 1'b1;
        bus.load_add = 1'b1;
        state_d      = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy            = 1'b1;
        bus.shift_hq_lq_q_1 = 1'b1;
        cnt_dec             = 1'b1;
        state_d             = cnt_last ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        // Reload so iter reads N while idle; zero is only visible in DONE.
        cnt_load = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      add_sub_q <= OP_ADD;
    end else begin
      state_q   <= state_d;
      add_sub_q <= add_sub_d;
    end
  end

  // Qualified by ADD so add_sub reads 0 everywhere else, even after a
  // corrupted state.
  assign bus.add_sub = add_sub_q && (state_q == S_ADD);
  assign bus.iter    = cnt_value;

endmodule

// File: tb/tb_module_booth_sequencer.sv
// Self-checking bench for module_booth_sequencer with N=4. A behavioural
// Booth datapath closes the q_lsb loop. Stimulus pushes expected run results
// into a scoreboard queue; a monitor pops and compares on every done pulse.
module tb_module_booth_sequencer;

  localparam int N = 4;
  localparam int W = $clog2(N + 1);

  typedef struct {
    int             done_cyc;  // cycle of done, LOAD = cycle 1
    int             n_add;
    logic [7:0]     seq;       // add_sub per load_add, first at bit 0
    int             n_shift;
    logic [2*N-1:0] product;
    int             gap;       // done-to-next-LOAD distance, -1 = unchecked
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  module_booth_sequencer_if #(.N(N)) bus ();

  module_booth_sequencer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural datapath; HQ has a guard bit so -M never overflows.
  logic [N-1:0]   m_in, b_in;
  logic [N:0]     m_reg, hq;
  logic [N-1:0]   lq;
  logic           q1;
  logic [2*N-1:0] product;

  always @(posedge clk) begin
    if (bus.load_a) m_reg <= {m_in[N-1], m_in};
    if (bus.load_b) begin
      lq <= b_in;
      hq <= '0;
      q1 <= 1'b0;
    end
    if (bus.load_add) hq <= bus.add_sub ? (hq - m_reg) : (hq + m_reg);
    if (bus.shift_hq_lq_q_1) {hq, lq, q1} <= {hq[N], hq, lq};
  end

  assign bus.q_lsb = {lq[0], q1};
  assign product   = {hq[N-1:0], lq};

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard consumer
  int         mcyc = 0;
  int         run_len = 0, m_add = 0, m_shift = 0;
  int         last_done_cyc = -100;
  int         done_count = 0;
  logic [7:0] seq = '0;
  bit         active = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    mcyc++;
    if (!rst) begin
      active    = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("strobe_onehot", 32'($onehot0({bus.load_a | bus.load_b, bus.load_add,
                                            bus.shift_hq_lq_q_1})), 32'd1);
      check("iter_le_n", 32'(bus.iter <= W'(N)), 32'd1);
      if (!bus.load_add) check("add_sub_outside_add", 32'(bus.add_sub), 32'd0);
      if (prev_done) check("done_width", 32'(bus.done), 32'd0);
      prev_done = bus.done;
      if (bus.load_a) begin
        check("load_b_with_load_a", 32'(bus.load_b), 32'd1);
        check("run_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0 && sb_q[0].gap >= 0)
          check("restart_gap", 32'(mcyc - last_done_cyc), 32'(sb_q[0].gap));
        active  = 1'b1;
        run_len = 1;
        m_add   = 0;
        m_shift = 0;
        seq     = '0;
      end else if (active) begin
        run_len++;
        check("busy_in_run", 32'(bus.busy), 32'd1);
        if (bus.load_add) begin
          if (m_add < 8) seq[m_add] = bus.add_sub;
          m_add++;
        end
        if (bus.shift_hq_lq_q_1) m_shift++;
        if (bus.done) begin
          done_count++;
          last_done_cyc = mcyc;
          active = 1'b0;
          check("done_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("done_cycle", 32'(run_len), 32'(e.done_cyc));
            check("n_load_add", 32'(m_add), 32'(e.n_add));
            check("add_sub_seq", 32'(seq), 32'(e.seq));
            check("n_shift", 32'(m_shift), 32'(e.n_shift));
            check("product", 32'(product), 32'(e.product));
            check("iter_at_done", 32'(bus.iter), 32'd0);
          end
        end
      end else begin
        check("idle_not_busy", 32'({bus.busy, bus.done}), 32'd0);
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_count < target; i++) @(negedge clk);
    check("done_timeout", 32'(done_count), 32'(target));
  endtask

  task automatic pulse_run(input logic [N-1:0] m, input logic [N-1:0] b, input exp_t e);
    int base;
    base = done_count;
    m_in = m;
    b_in = b;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(base + 1, 60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.start = 1'b0;
    m_in = '0;
    b_in = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_iter", 32'(bus.iter), 32'(N));
    check("rst_strobes", 32'({bus.load_a, bus.load_b, bus.load_add, bus.add_sub,
                              bus.shift_hq_lq_q_1, bus.done}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted while in ADD: everything clears asynchronously.
    base = done_count;
    m_in = 4'd3;
    b_in = 4'b0101;
    sb_q.push_back('{14, 4, 8'h05, 4, 8'd15, -1});
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30 && !bus.load_add; i++) @(negedge clk);
    check("reached_add", 32'(bus.load_add), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_iter", 32'(bus.iter), 32'(N));
    check("midrst_strobes", 32'({bus.load_a, bus.load_b, bus.load_add, bus.add_sub,
                                 bus.shift_hq_lq_q_1, bus.done}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    check("midrst_no_done", 32'(done_count), 32'(base));

    // Directed runs: {done_cyc, n_add, seq, n_shift, product, gap}
    pulse_run(4'd5,    4'b0000, '{10, 0, 8'h00, 4, 8'h00, -1});
    pulse_run(4'd3,    4'b0101, '{14, 4, 8'h05, 4, 8'h0F, -1});
    pulse_run(4'b1101, 4'b0101, '{14, 4, 8'h05, 4, 8'hF1, -1});

    // 3 * -8 = -24, with stray start pulses while busy.
    base = done_count;
    m_in = 4'b1000;
    b_in = 4'b0011;
    sb_q.push_back('{12, 2, 8'h01, 4, 8'hE8, -1});
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(base + 1, 60);
    repeat (15) @(negedge clk);
    check("no_extra_run", 32'(done_count), 32'(base + 1));

    // start held high: back-to-back runs with one IDLE cycle between.
    base = done_count;
    m_in = 4'd1;
    b_in = 4'b0000;
    sb_q.push_back('{10, 0, 8'h00, 4, 8'h00, -1});
    sb_q.push_back('{10, 0, 8'h00, 4, 8'h00, 2});
    @(negedge clk);
    bus.start = 1'b1;
    wait_done(base + 1, 60);
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_done(base + 2, 60);
    repeat (20) @(negedge clk);
    check("b2b_run_count", 32'(done_count), 32'(base + 2));
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
